// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared types for the snooping-bus arbiter.
// Bus message codes, MESI state codes and the arbiter FSM state enum.
package snoop_pkg;

  localparam logic [1:0] BUS_RD_MISS = 2'b00;
  localparam logic [1:0] BUS_WR_MISS = 2'b01;
  localparam logic [1:0] BUS_INVAL   = 2'b10;
  localparam logic [1:0] BUS_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BCAST,
    ST_COLLECT,
    ST_WB,
    ST_DONE
  } state_e;

endpackage

// File: rtl/snoop_bus_arbiter_if.sv
// Snoop bus bundle: core requests, broadcast, snoop responses, memory wb, completion.
// master = arbiter side, slave = cores/memory side.
interface snoop_bus_arbiter_if #(
  parameter int N_CORES = 4,
  parameter int AW      = 16,
  parameter int SRC_W   = 2
);
  import snoop_pkg::*;

  logic [N_CORES-1:0]    req_valid;
  logic [2*N_CORES-1:0]  req_msg;
  logic [AW*N_CORES-1:0] req_addr;
  logic                  bus_valid;
  logic [1:0]            bus_msg;
  logic [AW-1:0]         bus_addr;
  logic [SRC_W-1:0]      bus_src;
  logic [N_CORES-1:0]    snoop_valid;
  logic [N_CORES-1:0]    snoop_shared;
  logic [N_CORES-1:0]    snoop_wb;
  logic                  mem_wb_req;
  logic                  mem_wb_ack;
  logic [N_CORES-1:0]    done;
  logic                  done_shared;
  logic                  err;
  logic                  busy;

  modport master (
    input  req_valid, req_msg, req_addr,
    input  snoop_valid, snoop_shared, snoop_wb,
    input  mem_wb_ack,
    output bus_valid, bus_msg, bus_addr, bus_src,
    output mem_wb_req, done, done_shared, err, busy
  );

  modport slave (
    output req_valid, req_msg, req_addr,
    output snoop_valid, snoop_shared, snoop_wb,
    output mem_wb_ack,
    input  bus_valid, bus_msg, bus_addr, bus_src,
    input  mem_wb_req, done, done_shared, err, busy
  );

endinterface

// File: rtl/snoop_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr, wrapping.
// Ports: req, rr_ptr in; grant index, any_req out.
module rr_arbiter
  import snoop_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int SRC_W   = 2
) (
  input  logic [N_CORES-1:0] req,
  input  logic [SRC_W-1:0]   rr_ptr,
  output logic [SRC_W-1:0]   grant,
  output logic               any_req
);

  always_comb begin
    int j;
    j       = 0;
    grant   = '0;
    any_req = |req;
    // Walk offsets downward so the smallest offset from rr_ptr wins.
    for (int i = N_CORES - 1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      if (j >= N_CORES) j = j - N_CORES;
      if (req[j]) grant = SRC_W'(j);
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snooping-bus arbiter: grant, broadcast, collect snoops, writeback, complete.
// Ports: clock, reset_n, and the snoop_bus_arbiter_if master bundle sb.
module snoop_bus_arbiter
  import snoop_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int AW      = 16,
  parameter int SRC_W   = 2
) (
  input logic               clock,
  input logic               reset_n,
  snoop_bus_arbiter_if.master sb
);

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [1:0]         msg_q, msg_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [N_CORES-1:0] seen_q, seen_d;
  logic [N_CORES-1:0] wb_mask_q, wb_mask_d;
  logic               shared_q, shared_d;
  logic               err_q, err_d;

  logic [SRC_W-1:0]   grant;
  logic               any_req;
  logic [N_CORES-1:0] src_oh;
  logic [N_CORES-1:0] acc;
  logic [1:0]         gnt_msg;
  logic [AW-1:0]      gnt_addr;
  logic               all_seen;
  logic               multi_wb;

  rr_arbiter #(
    .N_CORES (N_CORES),
    .SRC_W   (SRC_W)
  ) u_rr (
    .req     (sb.req_valid),
    .rr_ptr  (rr_ptr_q),
    .grant   (grant),
    .any_req (any_req)
  );

  always_comb begin
    src_oh         = '0;
    src_oh[src_q]  = 1'b1;
    gnt_msg        = '0;
    gnt_addr       = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (grant == SRC_W'(i)) begin
        gnt_msg  = sb.req_msg[2*i +: 2];
        gnt_addr = sb.req_addr[AW*i +: AW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    src_d     = src_q;
    msg_d     = msg_q;
    addr_d    = addr_q;
    seen_d    = seen_q;
    wb_mask_d = wb_mask_q;
    shared_d  = shared_q;
    err_d     = err_q;
    acc       = '0;

    if (state_q == ST_BCAST || state_q == ST_COLLECT) begin
      acc       = sb.snoop_valid & ~src_oh;
      seen_d    = seen_q | acc;
      shared_d  = shared_q | (|(acc & sb.snoop_shared));
      // Per-core mask so repeated responses never double count.
      wb_mask_d = wb_mask_q | (acc & sb.snoop_wb);
    end

    all_seen = &(seen_d | src_oh);
    multi_wb = |(wb_mask_d & (wb_mask_d - N_CORES'(1)));

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          src_d    = grant;
          msg_d    = gnt_msg;
          addr_d   = gnt_addr;
          rr_ptr_d = (grant == SRC_W'(N_CORES - 1)) ?
                     SRC_W'(0) : grant + 1'b1;
          if (gnt_msg == BUS_ILLEGAL) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_BCAST;
          end
        end
      end
      ST_BCAST: state_d = ST_COLLECT;
      ST_COLLECT: begin
        if (all_seen) begin
          if (multi_wb) err_d = 1'b1;
          state_d = (|wb_mask_d) ? ST_WB : ST_DONE;
        end
      end
      ST_WB: begin
        if (sb.mem_wb_ack) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        seen_d    = '0;
        wb_mask_d = '0;
        shared_d  = 1'b0;
        err_d     = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      src_q     <= '0;
      msg_q     <= '0;
      addr_q    <= '0;
      seen_q    <= '0;
      wb_mask_q <= '0;
      shared_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      src_q     <= src_d;
      msg_q     <= msg_d;
      addr_q    <= addr_d;
      seen_q    <= seen_d;
      wb_mask_q <= wb_mask_d;
      shared_q  <= shared_d;
      err_q     <= err_d;
    end
  end

  assign sb.bus_valid   = (state_q == ST_BCAST);
  assign sb.bus_msg     = msg_q;
  assign sb.bus_addr    = addr_q;
  assign sb.bus_src     = src_q;
  assign sb.mem_wb_req  = (state_q == ST_WB);
  assign sb.done        = (state_q == ST_DONE) ? src_oh : '0;
  assign sb.done_shared = (state_q == ST_DONE) &&
                          (msg_q == BUS_RD_MISS) &&
                          (shared_q || (|wb_mask_q));
  assign sb.err         = (state_q == ST_DONE) && err_q;
  assign sb.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Scoreboard bench for snoop_bus_arbiter (N=4).
// Cores/memory modelled in wait_done; expectations queued per request.
module tb_snoop_bus_arbiter;

  logic clock;
  logic reset_n;

  snoop_bus_arbiter_if #(.N_CORES(4), .AW(16), .SRC_W(2)) sb ();

  snoop_bus_arbiter #(.N_CORES(4), .AW(16), .SRC_W(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .sb      (sb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         src;
    logic [3:0] done;
    logic       ds;
    logic       err;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [3:0] cfg_en, cfg_sh, cfg_wb;
  int         cfg_lag, cfg_ack;

  bit          o_found;
  logic [3:0]  o_done;
  logic        o_ds, o_err;
  int          o_cyc, o_nbc, o_wbc, o_nerr;
  logic [1:0]  o_msg, o_src;
  logic [15:0] o_addr;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int src, input logic ds, input logic err);
    exp_t e;
    e.src  = src;
    e.done = 4'b0001 << src;
    e.ds   = ds;
    e.err  = err;
    sbq.push_back(e);
  endtask

  task automatic pop(output exp_t e);
    e.src = -1; e.done = 'x; e.ds = 'x; e.err = 'x;
    if (sbq.size() > 0) e = sbq.pop_front();
  endtask

  task automatic set_cfg(input logic [3:0] en, input logic [3:0] sh,
                         input logic [3:0] wb, input int lag, input int ack);
    cfg_en = en; cfg_sh = sh; cfg_wb = wb; cfg_lag = lag; cfg_ack = ack;
  endtask

  task automatic req(input int core, input logic [1:0] msg, input logic [15:0] addr);
    sb.req_valid[core]        = 1'b1;
    sb.req_msg[2*core +: 2]   = msg;
    sb.req_addr[16*core +: 16] = addr;
  endtask

  // Cores and memory model: snoop reply cfg_lag cycles after bus_valid,
  // memory ack on the cfg_ack-th cycle of mem_wb_req.
  task automatic wait_done(input int budget);
    int age;
    age = -1;
    o_found = 0; o_done = '0; o_ds = 0; o_err = 0;
    o_cyc = 0; o_nbc = 0; o_wbc = 0; o_nerr = 0;
    o_msg = 'x; o_src = 'x; o_addr = 'x;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (sb.bus_valid) begin
        o_nbc++;
        o_msg = sb.bus_msg; o_src = sb.bus_src; o_addr = sb.bus_addr;
        age = 0;
      end else if (age >= 0) begin
        age++;
      end
      if (age == cfg_lag) begin
        sb.snoop_valid  = cfg_en & ~(4'b0001 << sb.bus_src);
        sb.snoop_shared = cfg_sh;
        sb.snoop_wb     = cfg_wb;
      end else begin
        sb.snoop_valid = '0; sb.snoop_shared = '0; sb.snoop_wb = '0;
      end
      if (sb.mem_wb_req) begin
        o_wbc++;
        sb.mem_wb_ack = (o_wbc == cfg_ack);
      end else begin
        sb.mem_wb_ack = 1'b0;
      end
      if (sb.err) o_nerr++;
      if (sb.done != 4'b0000) begin
        o_done = sb.done; o_ds = sb.done_shared; o_err = sb.err;
        o_cyc = c; o_found = 1;
        break;
      end
    end
    sb.snoop_valid = '0; sb.snoop_shared = '0; sb.snoop_wb = '0;
    sb.mem_wb_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    sb.req_valid = '0; sb.req_msg = '0; sb.req_addr = '0;
    sb.snoop_valid = '0; sb.snoop_shared = '0; sb.snoop_wb = '0;
    sb.mem_wb_ack = 1'b0;
    #2 reset_n = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({sb.bus_valid, sb.bus_msg, sb.bus_addr, sb.bus_src, sb.mem_wb_req,
         sb.done, sb.done_shared, sb.err, sb.busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got bv=%b busy=%b done=%b err=%b, want all 0",
               sb.bus_valid, sb.busy, sb.done, sb.err);
    end
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (sb.busy !== 1'b0 || sb.done !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_release got busy=%b done=%b, want 0/0000", sb.busy, sb.done);
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    int order[4] = '{0, 1, 3, 0};
    set_cfg(4'b1111, 4'b0000, 4'b0000, 0, 1);
    req(0, 2'b00, 16'h0100);
    req(1, 2'b00, 16'h0101);
    req(3, 2'b00, 16'h0103);
    foreach (order[k]) push(order[k], 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_done(20);
      pop(e);
      n_cmp++;
      if (!o_found) begin
        n_bad++;
        $display("FAIL rr_timeout_%0d no done within budget", k);
      end else begin
        if (o_done !== e.done) begin
          n_bad++;
          $display("FAIL rr_done_%0d got=%b want=%b", k, o_done, e.done);
        end
        n_cmp++;
        if (int'(o_src) != e.src || o_addr !== 16'h0100 + 16'(e.src)) begin
          n_bad++;
          $display("FAIL rr_src_%0d got src=%0d addr=%h want src=%0d", k, o_src, o_addr, e.src);
        end
        n_cmp++;
        if (o_ds !== e.ds || o_err !== e.err) begin
          n_bad++;
          $display("FAIL rr_flags_%0d got ds=%b err=%b want %b/%b", k, o_ds, o_err, e.ds, e.err);
        end
      end
    end
    sb.req_valid = '0;
    tick(); tick();
  endtask

  task automatic test_read_shared();
    exp_t e;
    set_cfg(4'b1011, 4'b0010, 4'b0000, 0, 1);
    req(2, 2'b00, 16'h1234);
    push(2, 1'b1, 1'b0);
    wait_done(20);
    pop(e);
    n_cmp++;
    if (!o_found) begin
      n_bad++;
      $display("FAIL rd_timeout no done within budget");
    end else begin
      if (o_nbc != 1 || o_msg !== 2'b00 || o_addr !== 16'h1234 || o_src !== 2'd2) begin
        n_bad++;
        $display("FAIL rd_bcast got n=%0d msg=%b addr=%h src=%0d want 1/00/1234/2",
                 o_nbc, o_msg, o_addr, o_src);
      end
      n_cmp++;
      if (o_cyc != 3) begin
        n_bad++;
        $display("FAIL rd_latency got=%0d want=3", o_cyc);
      end
      n_cmp++;
      if (o_done !== e.done || o_ds !== e.ds || o_err !== e.err) begin
        n_bad++;
        $display("FAIL rd_done got done=%b ds=%b err=%b want %b/%b/%b",
                 o_done, o_ds, o_err, e.done, e.ds, e.err);
      end
    end
    sb.req_valid[2] = 1'b0;
    tick();
    n_cmp++;
    if (sb.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_idle got busy=%b want 0", sb.busy);
    end
  endtask

  task automatic test_writeback();
    exp_t e;
    set_cfg(4'b1111, 4'b1000, 4'b1000, 0, 3);
    req(0, 2'b00, 16'h0A0A);
    push(0, 1'b1, 1'b0);
    wait_done(30);
    pop(e);
    n_cmp++;
    if (!o_found) begin
      n_bad++;
      $display("FAIL wb_timeout no done within budget");
    end else begin
      if (o_wbc != 3 || o_cyc != 6) begin
        n_bad++;
        $display("FAIL wb_timing got req_cycles=%0d latency=%0d want 3/6", o_wbc, o_cyc);
      end
      n_cmp++;
      if (o_done !== e.done || o_ds !== e.ds || o_err !== e.err || o_nerr != 0) begin
        n_bad++;
        $display("FAIL wb_done got done=%b ds=%b err=%b nerr=%0d want %b/%b/%b/0",
                 o_done, o_ds, o_err, o_nerr, e.done, e.ds, e.err);
      end
    end
    sb.req_valid[0] = 1'b0;
    tick();
  endtask

  task automatic test_late_snoop();
    exp_t e;
    // Responses land in the COLLECT cycle itself; write miss ignores sharers.
    set_cfg(4'b1111, 4'b1111, 4'b0000, 1, 1);
    req(1, 2'b01, 16'h0042);
    push(1, 1'b0, 1'b0);
    wait_done(20);
    pop(e);
    n_cmp++;
    if (!o_found) begin
      n_bad++;
      $display("FAIL late_timeout no done within budget");
    end else begin
      if (o_cyc != 3) begin
        n_bad++;
        $display("FAIL late_latency got=%0d want=3", o_cyc);
      end
      n_cmp++;
      if (o_done !== e.done || o_ds !== e.ds || o_msg !== 2'b01) begin
        n_bad++;
        $display("FAIL late_done got done=%b ds=%b msg=%b want %b/%b/01",
                 o_done, o_ds, o_msg, e.done, e.ds);
      end
    end
    sb.req_valid[1] = 1'b0;
    tick();
  endtask

  task automatic test_invalidate();
    exp_t e;
    set_cfg(4'b1111, 4'b1101, 4'b0000, 0, 1);
    req(1, 2'b10, 16'h0777);
    push(1, 1'b0, 1'b0);
    wait_done(20);
    pop(e);
    n_cmp++;
    if (!o_found) begin
      n_bad++;
      $display("FAIL inv_timeout no done within budget");
    end else begin
      if (o_done !== e.done || o_ds !== e.ds || o_wbc != 0 || o_err !== e.err) begin
        n_bad++;
        $display("FAIL inv_done got done=%b ds=%b wbreq=%0d err=%b want %b/%b/0/%b",
                 o_done, o_ds, o_wbc, o_err, e.done, e.ds, e.err);
      end
    end
    sb.req_valid[1] = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    exp_t e;
    set_cfg(4'b1111, 4'b0000, 4'b0000, 0, 1);
    req(3, 2'b11, 16'h0333);
    push(3, 1'b0, 1'b1);
    wait_done(20);
    pop(e);
    n_cmp++;
    if (!o_found) begin
      n_bad++;
      $display("FAIL ill_timeout no done within budget");
    end else begin
      if (o_nbc != 0 || o_cyc != 1) begin
        n_bad++;
        $display("FAIL ill_path got bcasts=%0d latency=%0d want 0/1", o_nbc, o_cyc);
      end
      n_cmp++;
      if (o_done !== e.done || o_err !== e.err || o_ds !== e.ds || o_nerr != 1) begin
        n_bad++;
        $display("FAIL ill_done got done=%b err=%b ds=%b nerr=%0d want %b/%b/%b/1",
                 o_done, o_err, o_ds, o_nerr, e.done, e.err, e.ds);
      end
    end
    sb.req_valid[3] = 1'b0;
    tick();
  endtask

  task automatic test_multi_wb();
    exp_t e;
    set_cfg(4'b1111, 4'b0110, 4'b0110, 0, 1);
    req(0, 2'b00, 16'h0C0C);
    push(0, 1'b1, 1'b1);
    wait_done(20);
    pop(e);
    n_cmp++;
    if (!o_found) begin
      n_bad++;
      $display("FAIL mwb_timeout no done within budget");
    end else begin
      if (o_done !== e.done || o_err !== e.err || o_ds !== e.ds) begin
        n_bad++;
        $display("FAIL mwb_done got done=%b err=%b ds=%b want %b/%b/%b",
                 o_done, o_err, o_ds, e.done, e.err, e.ds);
      end
      n_cmp++;
      if (o_nerr != 1 || o_wbc != 1 || o_cyc != 4) begin
        n_bad++;
        $display("FAIL mwb_timing got nerr=%0d wbreq=%0d latency=%0d want 1/1/4",
                 o_nerr, o_wbc, o_cyc);
      end
    end
    sb.req_valid[0] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_wb();
    exp_t e;
    set_cfg(4'b1111, 4'b1000, 4'b1000, 0, 1000);
    req(0, 2'b00, 16'hBEEF);
    wait_done(5);
    n_cmp++;
    if (o_found || sb.mem_wb_req !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_wb_setup got done_seen=%0d mem_wb_req=%b want 0/1",
               o_found, sb.mem_wb_req);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({sb.bus_valid, sb.bus_msg, sb.bus_addr, sb.bus_src, sb.mem_wb_req,
         sb.done, sb.done_shared, sb.err, sb.busy} !== '0) begin
      n_bad++;
      $display("FAIL rst_wb_outputs got wbreq=%b addr=%h busy=%b want all 0",
               sb.mem_wb_req, sb.bus_addr, sb.busy);
    end
    sb.req_valid = '0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (sb.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_wb_idle got busy=%b want 0", sb.busy);
    end
    set_cfg(4'b1111, 4'b0000, 4'b0000, 0, 1);
    req(0, 2'b00, 16'h0010);
    req(1, 2'b00, 16'h0011);
    push(0, 1'b0, 1'b0);
    push(1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      wait_done(20);
      pop(e);
      n_cmp++;
      if (!o_found) begin
        n_bad++;
        $display("FAIL rst_fresh_timeout_%0d no done within budget", k);
      end else if (o_done !== e.done || o_ds !== e.ds) begin
        n_bad++;
        $display("FAIL rst_fresh_%0d got done=%b ds=%b want %b/%b",
                 k, o_done, o_ds, e.done, e.ds);
      end
      sb.req_valid[e.src] = 1'b0;
    end
    tick(); tick();
  endtask

  initial begin
    set_cfg(4'b0000, 4'b0000, 4'b0000, 0, 1);
    test_reset();
    test_round_robin();
    test_read_shared();
    test_writeback();
    test_late_snoop();
    test_invalidate();
    test_illegal();
    test_multi_wb();
    test_reset_mid_wb();
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
- Shared snooping-bus stage sitting directly downstream of the per-core MESI emitters and upstream of the per-core MESI receptors.
- Round-robin picks one pending bus request, broadcasts it, and collects snoop responses (shared / writeback) from every other core.
- Sequences any writeback to memory, then completes the transaction back to the requester with a shared flag.
- The requester uses that flag to choose its final state on a read miss: S if shared, E if not.

Parameters:
N_CORES, 4, number of caches on the bus (1..8)
AW, 16, line-address width
SRC_W, 2, width of source id; must equal max(1, clog2(N_CORES))

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  N_CORES  core i has a bus request pending; held until done[i]
req_msg  in  2*N_CORES  core i message: 00 read miss, 01 write miss, 10 invalidate, 11 illegal
req_addr  in  AW*N_CORES  core i line address
bus_valid  out  1  broadcast strobe, one cycle per transaction
bus_msg  out  2  broadcast message
bus_addr  out  AW  broadcast address
bus_src  out  SRC_W  id of granted core
snoop_valid  in  N_CORES  core i snoop response strobe
snoop_shared  in  N_CORES  core i holds the line (S/E/M)
snoop_wb  in  N_CORES  core i held the line in M and must write back
mem_wb_req  out  1  writeback request to memory
mem_wb_ack  in  1  memory accepted writeback (1-cycle pulse)
done  out  N_CORES  one-hot completion pulse to the granted core
done_shared  out  1  valid with done: line present in another cache
err  out  1  one-cycle pulse: illegal msg or multiple writebacks
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, FSM to IDLE, rr_ptr=0, seen/shared/wb accumulators cleared. An assertion mid-transaction abandons it, including any pending writeback.
- FSM states: IDLE, BCAST, COLLECT, WB, DONE.
- IDLE: if any req_valid, grant the first set bit searching upward from rr_ptr with wrap. Latch src, msg, addr. Then set rr_ptr = (src+1) mod N_CORES.
  - msg==11: go to DONE with err flagged.
  - Otherwise go to BCAST.
- BCAST: exactly one cycle. bus_valid=1; bus_msg, bus_addr, bus_src are driven from the latched values and held stable until IDLE. Go to COLLECT.
- Snoop responses:
  - Accepted in BCAST and COLLECT, from core i != src only. Ignored in any other state, and ignored from src.
  - Each accepted response sets seen[i] and ORs snoop_shared[i] and snoop_wb[i] into shared_acc and wb_acc. Each wb-asserting core is counted in wb_cnt.
  - A repeated response from an already-seen core is ORed in but not recounted.
- COLLECT: complete when (seen | onehot(src)) is all ones, counting the current cycle's responses. N_CORES=1 completes on the first COLLECT cycle.
  - On completion, go to WB if wb_acc is set, else DONE.
  - wb_cnt > 1 raises err in the DONE cycle; the transaction still proceeds.
  - No timeout.
- WB: mem_wb_req=1 until the cycle mem_wb_ack=1, then DONE. An ack outside WB is ignored.
- DONE: exactly one cycle, then IDLE; accumulators clear.
  - done[src]=1.
  - done_shared = shared_acc | wb_acc when msg==00; 0 for 01/10.
  - err as flagged.
- Minimum latency, all responses arriving in BCAST: req seen in IDLE at cycle t, bus_valid at t+1, COLLECT at t+2, done at t+3, IDLE at t+4.
  - Writeback adds 1 + ack-wait cycles.
- Fairness: a core dropping req_valid before done is allowed. The transaction still completes, and the done pulse is lost to it.
- Simultaneous events:
  - A new request from any core during a transaction waits for IDLE.
  - A snoop_valid in the same cycle as completion is already counted.

Decomposition:
- Package snoop_pkg:
  - Bus message constants BUS_RD_MISS=2'b00, BUS_WR_MISS=2'b01, BUS_INVAL=2'b10.
  - MESI state codes I=00, S=01, E=10, M=11.
  - FSM state enum.
- Sub-module rr_arbiter (N_CORES): inputs req vector and rr_ptr, outputs grant index and any_req. Purely combinational.

Test Plan:
- N=4. Core 2 read miss, addr 0x1234; cores 0,1,3 respond at t+1 with core 1 shared=1 -> bus_valid at t+1 with msg=00, addr=0x1234, src=2; done=0100 at t+3; done_shared=1.
- Core 0 read miss; core 3 responds shared=1, wb=1; mem_wb_ack 3 cycles after mem_wb_req rises -> mem_wb_req held 3 cycles, then done=0001 with done_shared=1.
- Cores 0,1,3 request continuously, rr_ptr=0 -> grant order 0,1,3,0; each done one-hot matches bus_src.
- Core 1 invalidate with cores 0,2,3 all shared=1 -> done=0010, done_shared=0, no mem_wb_req.
- Core 3 msg=11 -> no bus_valid, done=1000 and err=1 in the same cycle. Separately, two cores assert wb -> err pulse coincident with done.
- reset_n low during WB -> all outputs 0 immediately. After release: busy=0, rr_ptr=0, a fresh request granted normally.
